hdmi_config_seq: RTL and testbench



---
 rtl/hdmi_config_seq.sv | 180 ++++++++++++++++++
 tb/tb_hdmi_config_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_config_seq.sv
// HDMI transmitter register-table sequencer: after a settle delay, walks a
// table of register writes through an I2C byte-writer with per-entry retry.
module hdmi_config_seq #(
  parameter int unsigned NUM_ENTRIES   = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [7:0]  DEV_ADDR      = 8'h72,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hpd,
  output logic [7:0] tbl_idx,
  input  logic [7:0] tbl_reg,
  input  logic [7:0] tbl_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_reg,
  output logic [7:0] cmd_data,
  input  logic       wr_done,
  input  logic       wr_nack,
  output logic       busy,
  output logic       config_done,
  output logic       error,
  output logic [7:0] err_idx
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_ISSUE, ST_WAIT, ST_DONE, ST_FAIL
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     idx_q, idx_d;
  logic [3:0]     retry_q, retry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           abort_q, abort_d;
  logic           cap_q, cap_d;
  logic [7:0]     creg_q, creg_d;
  logic [7:0]     cdata_q, cdata_d;
  logic [7:0]     err_idx_q, err_idx_d;

  logic           hpd_s1_q, hpd_s2_q, hpd_prev_q;
  logic [1:0]     warm_q;
  logic           hpd_rise, hpd_fall, trigger;

  // Edges are only honoured once the synchronizer and history flop hold real
  // pin samples, so a pin already high at reset release is not a rise.
  assign hpd_rise = (warm_q == 2'd3) &&  hpd_s2_q && !hpd_prev_q;
  assign hpd_fall = (warm_q == 2'd3) && !hpd_s2_q &&  hpd_prev_q;
  assign trigger  = start || hpd_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      cap_q      <= 1'b0;
      creg_q     <= '0;
      cdata_q    <= '0;
      err_idx_q  <= '0;
      hpd_s1_q   <= 1'b0;
      hpd_s2_q   <= 1'b0;
      hpd_prev_q <= 1'b0;
      warm_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      cap_q      <= cap_d;
      creg_q     <= creg_d;
      cdata_q    <= cdata_d;
      err_idx_q  <= err_idx_d;
      hpd_s1_q   <= hpd;
      hpd_s2_q   <= hpd_s1_q;
      hpd_prev_q <= hpd_s2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    cap_d     = cap_q;
    creg_d    = creg_q;
    cdata_d   = cdata_q;
    err_idx_d = err_idx_q;
    cmd_valid = 1'b0;
    cmd_reg   = creg_q;
    cmd_data  = cdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (trigger) begin
          state_d = ST_SETTLE;
          idx_d   = '0;
          retry_d = '0;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          abort_d = 1'b0;
        end else if (state_q == ST_DONE && hpd_fall) begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (hpd_fall) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ISSUE;
          cap_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_ISSUE: begin
        cmd_valid = 1'b1;
        // First ISSUE cycle forwards the live table entry and captures it;
        // later cycles replay the capture so the payload cannot move.
        if (!cap_q) begin
          cmd_reg  = tbl_reg;
          cmd_data = tbl_data;
          creg_d   = tbl_reg;
          cdata_d  = tbl_data;
          cap_d    = 1'b1;
        end
        if (hpd_fall) begin
          state_d = ST_IDLE;
        end else if (cmd_ready) begin
          state_d = ST_WAIT;
          abort_d = 1'b0;
        end
      end

      ST_WAIT: begin
        if (hpd_fall) abort_d = 1'b1;
        if (wr_done) begin
          if (abort_q || hpd_fall) begin
            state_d = ST_IDLE;
          end else if (!wr_nack) begin
            if (idx_q == 8'(NUM_ENTRIES - 1)) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 8'd1;
              retry_d = '0;
              cap_d   = 1'b0;
              state_d = ST_ISSUE;
            end
          end else if (retry_q < 4'(MAX_RETRY)) begin
            retry_d = retry_q + 4'd1;
            cap_d   = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            err_idx_d = idx_q;
            state_d   = ST_FAIL;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign tbl_idx     = idx_q;
  assign cmd_addr    = DEV_ADDR;
  assign busy        = (state_q == ST_SETTLE) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign config_done = (state_q == ST_DONE);
  assign error       = (state_q == ST_FAIL);
  assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_hdmi_config_seq.sv
// Self-checking bench for hdmi_config_seq: scenario table plus hand-written
// hot-plug and reset sequences, with a scoreboard of expected writes.
module tb_hdmi_config_seq;

  localparam int unsigned N  = 4;
  localparam int unsigned MR = 3;
  localparam int unsigned SC = 8;
  localparam logic [7:0]  DA = 8'h72;

  logic       clk = 1'b0;
  logic       rst, start, hpd, cmd_ready, wr_done, wr_nack;
  logic [7:0] tbl_idx, tbl_reg, tbl_data, cmd_addr, cmd_reg, cmd_data, err_idx;
  logic [7:0] tbl_xor;
  logic       cmd_valid, busy, config_done, error;

  int nvec, nmis;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] rg;
    logic [7:0] dt;
  } cmd_t;
  cmd_t sb[$];

  typedef struct {
    int         nack_entry;
    int         nack_count;
    int         stall_entry;
    int         exp_writes;
    logic       exp_done;
    logic       exp_error;
    logic [7:0] exp_err_idx;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_reg(input logic [7:0] i);
    return 8'h40 + i;
  endfunction

  function automatic logic [7:0] exp_data(input logic [7:0] i);
    return 8'hA0 ^ (i * 8'd17);
  endfunction

  assign tbl_reg  = exp_reg(tbl_idx);
  assign tbl_data = exp_data(tbl_idx) ^ tbl_xor;

  hdmi_config_seq #(
    .NUM_ENTRIES  (N),
    .MAX_RETRY    (MR),
    .DEV_ADDR     (DA),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hpd        (hpd),
    .tbl_idx    (tbl_idx),
    .tbl_reg    (tbl_reg),
    .tbl_data   (tbl_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_reg    (cmd_reg),
    .cmd_data   (cmd_data),
    .wr_done    (wr_done),
    .wr_nack    (wr_nack),
    .busy       (busy),
    .config_done(config_done),
    .error      (error),
    .err_idx    (err_idx)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_entry(input int i);
    cmd_t e;
    e.idx = 8'(i);
    e.rg  = exp_reg(8'(i));
    e.dt  = exp_data(8'(i));
    sb.push_back(e);
  endtask

  task automatic push_expected(input int ne, input int nc);
    int att;
    for (int i = 0; i < int'(N); i++) begin
      att = (i == ne) ? ((nc > int'(MR)) ? int'(MR) + 1 : nc + 1) : 1;
      for (int a = 0; a < att; a++) push_entry(i);
      if (i == ne && nc > int'(MR)) break;
    end
  endtask

  // trig: 1 = start pulse, 2 = raise hpd
  task automatic run_cfg(input int ne, input int nc, input int se, input int ab, input int trig,
                         output int writes, output int first_cv, output int done_lat);
    int         att[N];
    int         done_cnt, stall_left, cyc, last_done;
    logic       nack_pend;
    logic [7:0] held_reg, held_data;
    cmd_t       e;
    writes = 0; first_cv = -1; done_lat = -1; done_cnt = 0; cyc = 0; last_done = 0;
    nack_pend = 1'b0; held_reg = '0; held_data = '0;
    stall_left = (se >= 0) ? 5 : 0;
    for (int i = 0; i < int'(N); i++) att[i] = 0;
    @(negedge clk);
    if (trig == 1) start = 1'b1;
    if (trig == 2) hpd = 1'b1;
    while (cyc < 600) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      wr_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          wr_done   = 1'b1;
          wr_nack   = nack_pend;
          tbl_xor   = '0;
          last_done = cyc;
        end
      end
      cmd_ready = 1'b0;
      if (cmd_valid) begin
        if (first_cv < 0) first_cv = cyc;
        if (int'(tbl_idx) == se && stall_left > 0) begin
          if (stall_left == 5) begin
            held_reg  = cmd_reg;
            held_data = cmd_data;
          end else begin
            check("bp_reg_stable", cmd_reg, held_reg);
            check("bp_data_stable", cmd_data, held_data);
            tbl_xor = 8'(stall_left * 37 + 1);
          end
          stall_left--;
        end else begin
          cmd_ready = 1'b1;
          writes++;
          check("cmd_addr", cmd_addr, DA);
          if (sb.size() == 0) begin
            check("sb_unexpected_write", 1, 0);
          end else begin
            e = sb.pop_front();
            check("wr_idx", tbl_idx, e.idx);
            check("wr_reg", cmd_reg, e.rg);
            check("wr_data", cmd_data, e.dt);
          end
          att[tbl_idx]++;
          nack_pend = (int'(tbl_idx) == ne) && (att[tbl_idx] <= nc);
          if (int'(tbl_idx) == ab) begin
            hpd = 1'b0;
            ab  = -1;
            done_cnt = 8;
          end else begin
            done_cnt = 2;
          end
        end
      end
      if (first_cv >= 0 && !busy && !cmd_valid && done_cnt == 0 && !wr_done) begin
        done_lat = cyc - last_done;
        break;
      end
    end
    if (cyc >= 600) check("run_timeout", 1, 0);
    wr_done = 1'b0;
    cmd_ready = 1'b0;
  endtask

  task automatic quiet(input int n, input string nm);
    int c;
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (cmd_valid || busy) c++;
    end
    check(nm, c, 0);
  endtask

  initial begin
    int w, fcv, dl, t;
    nvec = 0; nmis = 0;
    rst = 1'b1; start = 1'b0; hpd = 1'b1; cmd_ready = 1'b0;
    wr_done = 1'b0; wr_nack = 1'b0; tbl_xor = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", config_done, 0);
    check("rst_error", error, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_err_idx", err_idx, 0);
    check("rst_tbl_idx", tbl_idx, 0);
    check("rst_cmd_reg", cmd_reg, 0);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_cmd_addr", cmd_addr, DA);
    rst = 1'b0;
    quiet(12, "hpd_high_at_release_no_trigger");

    vecs[0] = '{-1,  0, -1, 4, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{ 2,  2, -1, 6, 1'b1, 1'b0, 8'd0};
    vecs[2] = '{ 1, 99, -1, 5, 1'b0, 1'b1, 8'd1};
    vecs[3] = '{ 0,  3, -1, 7, 1'b1, 1'b0, 8'd0};
    vecs[4] = '{ 3,  4, -1, 7, 1'b0, 1'b1, 8'd3};
    vecs[5] = '{-1,  0,  1, 4, 1'b1, 1'b0, 8'd0};

    for (int k = 0; k < 6; k++) begin
      push_expected(vecs[k].nack_entry, vecs[k].nack_count);
      run_cfg(vecs[k].nack_entry, vecs[k].nack_count, vecs[k].stall_entry, -1, 1, w, fcv, dl);
      check($sformatf("v%0d_writes", k), w, vecs[k].exp_writes);
      check($sformatf("v%0d_first_cv_latency", k), fcv, 9);
      check($sformatf("v%0d_end_latency", k), dl, 1);
      check($sformatf("v%0d_config_done", k), config_done, vecs[k].exp_done);
      check($sformatf("v%0d_error", k), error, vecs[k].exp_error);
      check($sformatf("v%0d_busy", k), busy, 0);
      if (vecs[k].exp_error) check($sformatf("v%0d_err_idx", k), err_idx, vecs[k].exp_err_idx);
      check($sformatf("v%0d_sb_leftover", k), sb.size(), 0);
      quiet(20, $sformatf("v%0d_quiet_after", k));
      sb.delete();
    end

    // Hot-plug: hpd falls while entry 2 is in flight, then rises again.
    for (int i = 0; i < 3; i++) push_entry(i);
    run_cfg(-1, 0, -1, 2, 1, w, fcv, dl);
    check("hp_abort_writes", w, 3);
    check("hp_abort_latency", dl, 1);
    check("hp_abort_done", config_done, 0);
    check("hp_abort_error", error, 0);
    check("hp_abort_sb", sb.size(), 0);
    quiet(20, "hp_low_quiet");
    push_expected(-1, 0);
    run_cfg(-1, 0, -1, -1, 2, w, fcv, dl);
    check("hp_rise_writes", w, 4);
    check("hp_rise_first_cv", fcv, 11);
    check("hp_rise_done", config_done, 1);
    check("hp_rise_sb", sb.size(), 0);
    sb.delete();

    // Reset while waiting for wr_done of the first write.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmd_ready = 1'b1;
    t = 0;
    while (!cmd_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("rst_seq_cmd_valid", cmd_valid, 1);
    @(negedge clk);
    check("rst_seq_in_wait_busy", busy, 1);
    check("rst_seq_in_wait_cv", cmd_valid, 0);
    check("rst_seq_pre_err_idx", err_idx, 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_cmd_valid", cmd_valid, 0);
    check("async_rst_err_idx", err_idx, 0);
    check("async_rst_cmd_reg", cmd_reg, 0);
    check("async_rst_cmd_data", cmd_data, 0);
    check("async_rst_done", config_done, 0);
    @(negedge clk);
    rst = 1'b0;
    cmd_ready = 1'b0;
    quiet(30, "post_rst_quiet");
    push_expected(-1, 0);
    run_cfg(-1, 0, -1, -1, 1, w, fcv, dl);
    check("post_rst_writes", w, 4);
    check("post_rst_first_cv", fcv, 9);
    check("post_rst_done", config_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
